pow_5_shared_scheduler: RTL

//   Shares one iterative 18-bit multiplier among N_REQ clients that each need n^5.

---
 rtl/pow_5_shared_scheduler.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/pow_5_shared_scheduler.sv
// Shared pow-5 unit: round-robin arbiter in front of one iterative W-bit multiplier.
// A granted operand n is raised to n^5 (mod 2^W) with four multiplies, then the
// result is returned with the requester index.
module pow_5_shared_scheduler #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned W     = 18,
  localparam int unsigned ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] req_n,
  output logic [N_REQ-1:0]   gnt,
  output logic               busy,
  output logic               res_valid,
  output logic [ID_W-1:0]    res_id,
  output logic [W-1:0]       res
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [W-1:0]      op_q, op_d;
  logic [W-1:0]      acc_q, acc_d;
  logic [W-1:0]      res_q, res_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [ID_W-1:0]   cur_id_q, cur_id_d;
  logic [ID_W-1:0]   rr_q, rr_d;
  logic [ID_W-1:0]   res_id_q, res_id_d;
  logic              busy_q, busy_d;
  logic              res_valid_q, res_valid_d;

  logic              any_c;
  logic [ID_W-1:0]   sel_c;
  logic [ID_W:0]     sum_c;
  logic [W-1:0]      sel_op_c;
  logic [N_REQ-1:0]  gnt_c;

  // Round-robin search: first set req bit starting at rr_q, wrapping modulo N_REQ.
  always_comb begin
    any_c = 1'b0;
    sel_c = '0;
    sum_c = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      sum_c = {1'b0, rr_q} + (ID_W+1)'(k);
      if (sum_c >= (ID_W+1)'(N_REQ)) begin
        sum_c = sum_c - (ID_W+1)'(N_REQ);
      end
      if (!any_c && req[sum_c[ID_W-1:0]]) begin
        any_c = 1'b1;
        sel_c = sum_c[ID_W-1:0];
      end
    end
  end

  // Operand mux for the selected client.
  always_comb begin
    sel_op_c = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (ID_W'(i) == sel_c) begin
        sel_op_c = req_n[i*W +: W];
      end
    end
  end

  // Grant is combinational and only offered in IDLE outside reset.
  always_comb begin
    gnt_c = '0;
    if (reset_n && (state_q == ST_IDLE) && any_c) begin
      gnt_c[sel_c] = 1'b1;
    end
  end

  assign gnt       = gnt_c;
  assign busy      = busy_q;
  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res       = res_q;

  // Next-state and datapath next values.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    cur_id_d    = cur_id_q;
    rr_d        = rr_q;
    res_d       = res_q;
    res_id_d    = res_id_q;
    busy_d      = 1'b0;
    res_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_c) begin
          op_d     = sel_op_c;
          acc_d    = sel_op_c;
          cnt_d    = 2'd0;
          cur_id_d = sel_c;
          if (N_REQ == 1) begin
            rr_d = '0;
          end else if (sel_c == ID_W'(N_REQ - 1)) begin
            rr_d = '0;
          end else begin
            rr_d = sel_c + ID_W'(1);
          end
          state_d = ST_MUL;
          busy_d  = 1'b1;
        end
      end
      ST_MUL: begin
        acc_d  = W'(acc_q * op_q);
        cnt_d  = cnt_q + 2'd1;
        busy_d = 1'b1;
        if (cnt_q == 2'd3) begin
          state_d     = ST_DONE;
          res_d       = acc_d;
          res_id_d    = cur_id_q;
          res_valid_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      acc_q       <= '0;
      cnt_q       <= 2'd0;
      cur_id_q    <= '0;
      rr_q        <= '0;
      res_q       <= '0;
      res_id_q    <= '0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      cur_id_q    <= cur_id_d;
      rr_q        <= rr_d;
      res_q       <= res_d;
      res_id_q    <= res_id_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
    end
  end

endmodule
